// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control FSM for the FPG8 datapath.
// Fetch/decode/sequence, bus and register strobes, ALU function select,
// PSW update gating via Z_in, branch resolution from {N,Z}, and memory
// wait timeout into a sticky ERROR state.
// Optional build macro: SINGLE_STEP_EN adds a 'step' input that releases
// one instruction per rising edge.
module instr_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 4
) (
   input  logic        clk,
   input  logic        reset,
`ifdef SINGLE_STEP_EN
   input  logic        step,
`endif
   input  logic [3:0]  IR_opcode,
   input  logic        IR_S,
   input  logic [2:0]  IR_alu,
   input  logic [1:0]  IR_cond,
   input  logic [1:0]  PSW_in,
   input  logic        mem_ready,
   output logic [12:0] ctrl,
   output logic [2:0]  ALU_control,
   output logic [3:0]  state_out,
   output logic        halted,
   output logic        bus_error
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_FWAIT  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_ALU1   = 4'd3;
   localparam logic [3:0] S_ALU2   = 4'd4;
   localparam logic [3:0] S_ALU3   = 4'd5;
   localparam logic [3:0] S_MADDR  = 4'd6;
   localparam logic [3:0] S_MWAIT  = 4'd7;
   localparam logic [3:0] S_BR     = 4'd8;
   localparam logic [3:0] S_HALT   = 4'd9;
   localparam logic [3:0] S_ERROR  = 4'd10;

   localparam logic [12:0] C_PC_OUT  = 13'h0001;
   localparam logic [12:0] C_MAR_IN  = 13'h0002;
   localparam logic [12:0] C_MEM_RD  = 13'h0004;
   localparam logic [12:0] C_IR_IN   = 13'h0008;
   localparam logic [12:0] C_PC_INC  = 13'h0010;
   localparam logic [12:0] C_RS_OUT  = 13'h0020;
   localparam logic [12:0] C_A_IN    = 13'h0040;
   localparam logic [12:0] C_Z_IN    = 13'h0080;
   localparam logic [12:0] C_Z_OUT   = 13'h0100;
   localparam logic [12:0] C_RD_IN   = 13'h0200;
   localparam logic [12:0] C_MDR_OUT = 13'h0400;
   localparam logic [12:0] C_MEM_WR  = 13'h0800;
   localparam logic [12:0] C_PC_IN   = 13'h1000;

   logic [3:0]      state_q, state_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [12:0]     ctrl_raw;
   logic            go;
   logic            taken;
   logic            wait_expired;
   logic            unused_ir_s;

   // IR.S only qualifies PSW writes in the datapath; the sequencer ignores it.
   assign unused_ir_s = IR_S;

`ifdef SINGLE_STEP_EN
   logic [2:0] step_sync_q;
   logic       step_pend_q, step_pend_d;
   logic       step_rise;

   assign step_rise = step_sync_q[1] & ~step_sync_q[2];
   assign go        = step_pend_q;

   // A new edge always survives; the held one is consumed as FETCH proceeds.
   always_comb begin
      step_pend_d = step_rise | (step_pend_q & (state_q != S_FETCH));
   end

   // Two-flop synchronizer plus delayed copy for edge detect; pending latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         step_sync_q <= '0;
         step_pend_q <= 1'b0;
      end else begin
         step_sync_q <= {step_sync_q[1:0], step};
         step_pend_q <= step_pend_d;
      end
   end
`else
   assign go = 1'b1;
`endif

   // Last allowed wait cycle: the counter has already counted MEM_TIMEOUT-1 misses.
   assign wait_expired = (to_q == TO_W'(MEM_TIMEOUT - 1));

   // Branch condition from {N,Z}.
   always_comb begin
      case (IR_cond)
         2'b00:   taken = 1'b1;
         2'b01:   taken = PSW_in[0];
         2'b10:   taken = PSW_in[1];
         default: taken = ~PSW_in[0] & ~PSW_in[1];
      endcase
   end

   // Next state and raw strobes.
   always_comb begin
      state_d  = state_q;
      ctrl_raw = '0;
      case (state_q)
         S_FETCH: begin
            if (go) begin
               ctrl_raw = C_PC_OUT | C_MAR_IN | C_MEM_RD;
               state_d  = S_FWAIT;
            end
         end
         S_FWAIT: begin
            ctrl_raw = C_MEM_RD;
            if (mem_ready) begin
               ctrl_raw = C_MEM_RD | C_IR_IN | C_PC_INC;
               state_d  = S_DECODE;
            end else if (wait_expired) begin
               state_d = S_ERROR;
            end
         end
         S_DECODE: begin
            if (IR_opcode <= 4'd5)                         state_d = S_ALU1;
            else if (IR_opcode == 4'd6 || IR_opcode == 4'd7) state_d = S_MADDR;
            else if (IR_opcode == 4'd8)                    state_d = S_BR;
            else if (IR_opcode == 4'd9)                    state_d = S_HALT;
            else                                           state_d = S_FETCH;
         end
         S_ALU1: begin
            ctrl_raw = C_RS_OUT | C_A_IN;
            state_d  = S_ALU2;
         end
         S_ALU2: begin
            ctrl_raw = C_RS_OUT | C_Z_IN;
            state_d  = S_ALU3;
         end
         S_ALU3: begin
            ctrl_raw = C_Z_OUT | C_RD_IN;
            state_d  = S_FETCH;
         end
         S_MADDR: begin
            ctrl_raw = C_RS_OUT | C_MAR_IN;
            state_d  = S_MWAIT;
         end
         S_MWAIT: begin
            // IR is stable for the whole instruction, so it selects LOAD vs STORE.
            if (IR_opcode == 4'd7)  ctrl_raw = C_MDR_OUT | C_MEM_WR;
            else if (mem_ready)     ctrl_raw = C_MEM_RD | C_RD_IN;
            else                    ctrl_raw = C_MEM_RD;
            if (mem_ready)          state_d = S_FETCH;
            else if (wait_expired)  state_d = S_ERROR;
         end
         S_BR: begin
            if (taken) ctrl_raw = C_RS_OUT | C_PC_IN;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_ERROR;
      endcase
   end

   // Wait counter: cleared on entry to a wait state, counts cycles without ready.
   always_comb begin
      to_d = to_q;
      if ((state_d == S_FWAIT && state_q != S_FWAIT) ||
          (state_d == S_MWAIT && state_q != S_MWAIT))
         to_d = '0;
      else if ((state_q == S_FWAIT || state_q == S_MWAIT) && !mem_ready)
         to_d = to_q + 1'b1;
   end

   // State and timeout registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         to_q    <= to_d;
      end
   end

   // Reset masks strobes immediately so nothing is driven while held in reset.
   always_comb begin
      ctrl        = reset ? ctrl_raw : '0;
      ALU_control = (reset && (state_q == S_ALU1 || state_q == S_ALU2 ||
                               state_q == S_ALU3)) ? IR_alu : 3'b000;
   end

   assign state_out = state_q;
   assign halted    = (state_q == S_HALT) || (state_q == S_ERROR);
   assign bus_error = (state_q == S_ERROR);

endmodule
